// File: rtl/id_hazard_interlock.sv
// id_hazard_interlock: stalls ID when forwarding cannot cover an EX writer or a MEM load,
// tracks rd of EX/MEM instructions, and keeps stall statistics.
module id_hazard_interlock #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             flush,
    input  logic             mem_ready,
    output logic             id_stall,
    output logic             ex_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic             stall_timeout
);
    typedef enum logic [1:0] {RUN = 2'd0, HAZ = 2'd1, MEMWAIT = 2'd2} state_t;
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } slot_t;

    localparam int RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    slot_t ex_s, mem_s;
    state_t cur, nxt;
    logic [RUN_W-1:0] run_cnt, run_nxt;
    logic haz;

    function automatic logic match(slot_t s, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2);
        return s.v & s.rw & (s.rd != 5'd0) & ((u1 & (rs1 == s.rd)) | (u2 & (rs2 == s.rd)));
    endfunction

    assign haz = id_valid & (match(ex_s, id_rs1, id_rs2, id_rs1_used, id_rs2_used)
                 | (match(mem_s, id_rs1, id_rs2, id_rs1_used, id_rs2_used) & mem_s.mr));
    // Gated by rst_n so every output reads 0 the moment reset asserts.
    assign id_stall  = rst_n & (haz | ~mem_ready);
    assign ex_bubble = rst_n & mem_ready & (haz | flush);
    assign state     = cur;
    assign run_nxt   = ~id_stall ? '0 : (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;

    always_comb begin
        nxt = RUN;
        if (!mem_ready) nxt = MEMWAIT;
        else if (haz)   nxt = HAZ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= RUN;
        end else begin
            cur <= nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_s  <= '0;
            mem_s <= '0;
        end else if (mem_ready) begin
            mem_s <= ex_s;
            ex_s  <= (ex_bubble || !id_valid) ? '0 : {1'b1, id_rd, id_regwrite, id_memread};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count   <= '0;
            run_cnt       <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (id_stall && stall_count != '1) stall_count <= stall_count + 1'b1;
            run_cnt       <= run_nxt;
            stall_timeout <= stall_timeout | (run_nxt == RUN_MAX);
        end
    end
endmodule

// File: tb/tb_id_hazard_interlock.sv
// tb_id_hazard_interlock: directed scenarios plus random traffic checked against an
// in-flight instruction model; a CNT_W=4 twin exercises counter saturation.
module tb_id_hazard_interlock;
    logic clk = 1'b0, rst_n = 1'b0;
    logic id_valid, id_regwrite, id_memread, id_rs1_used, id_rs2_used, flush, mem_ready;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic id_stall, ex_bubble, stall_timeout, id_stall4, ex_bubble4, stall_timeout4;
    logic [1:0] state, state4;
    logic [15:0] stall_count;
    logic [3:0] stall_count4;
    int checks = 0, errors = 0;
    bit done = 0;

    always #5 clk = ~clk;

    id_hazard_interlock dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .flush(flush), .mem_ready(mem_ready), .id_stall(id_stall),
        .ex_bubble(ex_bubble), .state(state), .stall_count(stall_count), .stall_timeout(stall_timeout)
    );
    id_hazard_interlock #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used), .flush(flush), .mem_ready(mem_ready), .id_stall(id_stall4),
        .ex_bubble(ex_bubble4), .state(state4), .stall_count(stall_count4), .stall_timeout(stall_timeout4)
    );

    // Model: the two older instructions in flight (index 0 = EX, 1 = MEM) and statistics.
    bit pv[2], prw[2], pmr[2];
    int prd[2];
    int m_state, m_cnt, m_cnt4, m_run;
    bit m_to;

    function automatic bit reads(int i);
        return pv[i] && prw[i] && prd[i] != 0 &&
               ((id_rs1_used && id_rs1 == prd[i]) || (id_rs2_used && id_rs2 == prd[i]));
    endfunction
    function automatic bit m_haz();
        return id_valid && (reads(0) || (reads(1) && pmr[1]));
    endfunction
    function automatic bit m_stall();
        return rst_n && (m_haz() || !mem_ready);
    endfunction
    function automatic bit m_bubble();
        return rst_n && mem_ready && (m_haz() || flush);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin pv[i] = 0; prw[i] = 0; pmr[i] = 0; prd[i] = 0; end
            m_state = 0; m_cnt = 0; m_cnt4 = 0; m_run = 0; m_to = 0;
        end else begin
            bit st, bb, hz;
            st = m_stall(); bb = m_bubble(); hz = m_haz();
            m_state = !mem_ready ? 2 : hz ? 1 : 0;
            if (st) begin
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                m_cnt4 = (m_cnt4 < 15) ? m_cnt4 + 1 : m_cnt4;
                m_run++;
            end else m_run = 0;
            if (m_run >= 64) m_to = 1;
            if (mem_ready) begin
                pv[1] = pv[0]; prd[1] = prd[0]; prw[1] = prw[0]; pmr[1] = pmr[0];
                if (bb || !id_valid) begin pv[0] = 0; prd[0] = 0; prw[0] = 0; pmr[0] = 0; end
                else begin pv[0] = 1; prd[0] = id_rd; prw[0] = id_regwrite; pmr[0] = id_memread; end
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (!done) begin
        chk("m_stall", id_stall, m_stall());
        chk("m_bubble", ex_bubble, m_bubble());
        chk("m_state", state, m_state);
        chk("m_count", stall_count, m_cnt);
        chk("m_timeout", stall_timeout, m_to);
        chk("m_stall4", id_stall4, m_stall());
        chk("m_count4", stall_count4, m_cnt4);
    end

    task automatic set_id(bit v, int rd, bit rw, bit mr, int rs1, int rs2, bit u1, bit u2);
        id_valid = v; id_rd = 5'(rd); id_regwrite = rw; id_memread = mr;
        id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rs1_used = u1; id_rs2_used = u2;
    endtask
    task automatic cyc();
        @(posedge clk); #1;
    endtask
    task automatic do_reset();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); flush = 0; mem_ready = 1;
        #1 rst_n = 0;
        @(posedge clk); #2 rst_n = 1;
    endtask

    initial begin
        set_id(0, 0, 0, 0, 0, 0, 0, 0); flush = 0; mem_ready = 1;
        #2;
        chk("rst_stall", id_stall, 0); chk("rst_state", state, 0); chk("rst_count", stall_count, 0);
        @(posedge clk); #2 rst_n = 1;
        // ALU producer: one stall cycle
        set_id(1, 5, 1, 0, 0, 0, 0, 0); cyc();
        set_id(1, 6, 1, 0, 5, 0, 1, 0); #1;
        chk("alu_stall", id_stall, 1); chk("alu_bubble", ex_bubble, 1);
        cyc(); chk("alu_resolved", id_stall, 0); chk("alu_state", state, 1);
        // load producer: two stall cycles
        do_reset();
        set_id(1, 7, 1, 1, 0, 0, 0, 0); cyc();
        set_id(1, 8, 1, 0, 0, 7, 0, 1); #1; chk("ld_stall1", id_stall, 1);
        cyc(); chk("ld_stall2", id_stall, 1); chk("ld_state1", state, 1);
        cyc(); chk("ld_free", id_stall, 0); chk("ld_state2", state, 1);
        set_id(0, 0, 0, 0, 0, 0, 0, 0); cyc();
        chk("ld_state3", state, 0); chk("ld_count", stall_count, 2);
        // x0 writer and unused source
        set_id(1, 0, 1, 0, 0, 0, 0, 0); cyc();
        set_id(1, 9, 1, 0, 0, 0, 1, 1); #1; chk("x0_nostall", id_stall, 0);
        cyc(); set_id(1, 4, 1, 0, 9, 0, 0, 0); #1; chk("unused_nostall", id_stall, 0);
        // load in MEM frozen by mem_ready
        cyc(); set_id(1, 3, 1, 1, 0, 0, 0, 0); cyc();
        set_id(0, 0, 0, 0, 0, 0, 0, 0); cyc();
        set_id(1, 10, 1, 0, 3, 0, 1, 0); mem_ready = 0; #1;
        chk("mw_stall", id_stall, 1); chk("mw_bubble", ex_bubble, 0);
        repeat (3) begin cyc(); chk("mw_state", state, 2); chk("mw_hold", id_stall, 1); end
        mem_ready = 1; #1; chk("mw_loaduse", id_stall, 1); chk("mw_lu_bubble", ex_bubble, 1);
        cyc(); chk("mw_done", id_stall, 0); chk("mw_state_haz", state, 1);
        // flush without hazard
        set_id(1, 12, 1, 0, 0, 0, 0, 0); flush = 1; #1;
        chk("fl_bubble", ex_bubble, 1); chk("fl_stall", id_stall, 0);
        cyc(); flush = 0; set_id(1, 13, 1, 0, 12, 0, 1, 0); #1; chk("fl_cleared", id_stall, 0);
        // timeout, saturation, mid-stall reset
        do_reset(); set_id(0, 0, 0, 0, 0, 0, 0, 0); mem_ready = 0;
        repeat (63) cyc();
        chk("to_before", stall_timeout, 0);
        cyc(); chk("to_set", stall_timeout, 1); chk("sat4", stall_count4, 15); chk("cnt64", stall_count, 64);
        mem_ready = 1; cyc(); chk("to_sticky", stall_timeout, 1);
        mem_ready = 0; #2 rst_n = 0; #1;
        chk("mid_rst_stall", id_stall, 0); chk("mid_rst_bubble", ex_bubble, 0);
        chk("mid_rst_to", stall_timeout, 0); chk("mid_rst_cnt", stall_count, 0);
        @(posedge clk); #2 rst_n = 1; mem_ready = 1;
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc();
            set_id($urandom_range(0, 5) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1), $urandom_range(0, 1));
            flush = $urandom_range(0, 7) == 0;
            mem_ready = $urandom_range(0, 9) != 0;
            if ($urandom_range(0, 299) == 0) begin rst_n = 0; #1 rst_n = 1; end
        end
        @(posedge clk); #1 done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
